cache_fill_fsm: RTL

Miss handler for the 64-set cache with 16-byte blocks. On a miss it latches the block address and issues eight word reads to main memory. It writes each returned word into the data array and writes the tag when the block completes. Its `set_index` output drives the set-decoder stage, which turns the 6-bit set into the 64-bit block enable used by the data and tag arrays.

---
 rtl/cache_fill_fsm_if.sv | 28 ++
 rtl/cache_fill_fsm.sv | 107 ++++++++++
 2 files changed

// File: rtl/cache_fill_fsm_if.sv
// Signal bundle between the cache miss handler, main memory and the data/tag arrays.
interface cache_fill_fsm_if;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data_in;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic [5:0]  set_index;
    logic [5:0]  tag_out;
    logic [7:0]  word_enable;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] data_out;

    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data_in,
        output fsm_busy, mem_read_en, memory_address, set_index, tag_out,
        output word_enable, write_data_array, write_tag_array, data_out
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data_in,
        input  fsm_busy, mem_read_en, memory_address, set_index, tag_out,
        input  word_enable, write_data_array, write_tag_array, data_out
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Miss handler: reads one 8-word block from memory into the data array, then writes the tag.
// CACHE_FILL_CRITICAL_WORD_FIRST_EN makes the fill start at the missed word and wrap.
module cache_fill_fsm #(
    parameter int unsigned WORDS = 8
) (
    input logic              clk,
    input logic              rst_n,
    cache_fill_fsm_if.master bus
);
    localparam int unsigned   CntW   = $clog2(WORDS);
    localparam logic [CntW:0] CntMax = (CntW + 1)'(WORDS);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e          state_q, state_d;
    logic [5:0]      tag_q, tag_d;
    logic [5:0]      set_q, set_d;
    logic [CntW-1:0] start_w_q, start_w_d;
    logic [CntW:0]   issue_q, issue_d;
    logic [CntW:0]   recv_q, recv_d;
    logic [CntW-1:0] miss_start_w;
    logic [CntW-1:0] issue_word;
    logic [CntW-1:0] recv_word;
    logic            unused_byte_bit;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign miss_start_w = bus.miss_address[CntW:1];
`else
    logic unused_word_bits;
    assign unused_word_bits = ^bus.miss_address[CntW:1];
    assign miss_start_w     = '0;
`endif
    assign unused_byte_bit = bus.miss_address[0];

    // Word indices wrap inside the block, so the request never carries into the set bits.
    assign issue_word = start_w_q + issue_q[CntW-1:0];
    assign recv_word  = start_w_q + recv_q[CntW-1:0];

    assign bus.set_index = set_q;
    assign bus.tag_out   = tag_q;
    assign bus.data_out  = bus.memory_data_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tag_q     <= '0;
            set_q     <= '0;
            start_w_q <= '0;
            issue_q   <= '0;
            recv_q    <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            set_q     <= set_d;
            start_w_q <= start_w_d;
            issue_q   <= issue_d;
            recv_q    <= recv_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        tag_d                = tag_q;
        set_d                = set_q;
        start_w_d            = start_w_q;
        issue_d              = issue_q;
        recv_d               = recv_q;
        bus.fsm_busy         = 1'b0;
        bus.mem_read_en      = 1'b0;
        bus.memory_address   = '0;
        bus.word_enable      = '0;
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.miss_detected) begin
                    state_d   = StFill;
                    tag_d     = bus.miss_address[15:10];
                    set_d     = bus.miss_address[9:4];
                    start_w_d = miss_start_w;
                    issue_d   = '0;
                    recv_d    = '0;
                end
            end
            StFill: begin
                bus.fsm_busy = 1'b1;
                if (issue_q < CntMax) begin
                    bus.mem_read_en    = 1'b1;
                    bus.memory_address = {tag_q, set_q, issue_word, 1'b0};
                    issue_d            = issue_q + 1'b1;
                end
                // Responses come back in request order, so recv_q alone names the word.
                if (bus.memory_data_valid) begin
                    bus.write_data_array       = 1'b1;
                    bus.word_enable[recv_word] = 1'b1;
                    recv_d                     = recv_q + 1'b1;
                    if (recv_q == CntMax - 1'b1) begin
                        bus.write_tag_array = 1'b1;
                        state_d             = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule
